pwm_peripheral: RTL and testbench

PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

---
 rtl/pwm_peripheral.sv | 107 ++++++++++
 tb/tb_pwm_peripheral.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16-pin output block, each pin static or shared 8-bit PWM.
// Build option: define PWM_DUTY_SHADOW_EN to latch duty only at period wrap.
//
// Ports:
//   clk              system clock, all state on rising edge
//   rst_n            asynchronous active-low reset
//   en_reg_out_7_0   output enables for out[7:0]
//   en_reg_out_15_8  output enables for out[15:8]
//   en_reg_pwm_7_0   PWM-mode selects for out[7:0]
//   en_reg_pwm_15_8  PWM-mode selects for out[15:8]
//   pwm_duty_cycle   duty value, 0x00 = always low, 0xFF = always high
//   out              registered pin drive
//   period_start     one-clock pulse when the PWM count wraps to 0x00
module pwm_peripheral #(
    parameter int unsigned PRESCALE = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam logic [15:0] PS_MAX = 16'(PRESCALE - 1);

    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [15:0] prescaler_q, prescaler_d;
    logic [7:0]  pwm_count_q, pwm_count_d;
    logic [15:0] out_q, out_d;
    logic        period_start_q, period_start_d;
    logic        tick;
    logic        wrap;
    logic        pwm_signal;
    logic [7:0]  duty_eff;

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    always_comb begin
        tick           = (prescaler_q == PS_MAX);
        prescaler_d    = tick ? 16'd0 : prescaler_q + 16'd1;
        pwm_count_d    = tick ? pwm_count_q + 8'd1 : pwm_count_q;
        wrap           = tick && (pwm_count_q == 8'hFF);
        period_start_d = wrap;
    end

`ifdef PWM_DUTY_SHADOW_EN
    logic [7:0] duty_shadow_q, duty_shadow_d;

    // Duty is captured on the wrapping tick so a whole period uses one value.
    always_comb begin
        duty_shadow_d = wrap ? pwm_duty_cycle : duty_shadow_q;
        duty_eff      = duty_shadow_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_shadow_q <= 8'h00;
        end else begin
            duty_shadow_q <= duty_shadow_d;
        end
    end
`else
    always_comb begin
        duty_eff = pwm_duty_cycle;
    end
`endif

    // The compare looks at the count value being loaded this edge, so the
    // registered pin rises on the same edge that raises period_start.
    always_comb begin
        if (duty_eff == 8'hFF) begin
            pwm_signal = 1'b1;
        end else begin
            pwm_signal = (pwm_count_d < duty_eff);
        end
        out_d = '0;
        for (int i = 0; i < 16; i++) begin
            if (en_out[i]) begin
                out_d[i] = en_pwm[i] ? pwm_signal : 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q    <= 16'd0;
            pwm_count_q    <= 8'd0;
            out_q          <= 16'h0000;
            period_start_q <= 1'b0;
        end else begin
            prescaler_q    <= prescaler_d;
            pwm_count_q    <= pwm_count_d;
            out_q          <= out_d;
            period_start_q <= period_start_d;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: directed and random checks of pwm_peripheral against
// an arithmetic model of the count, the duty compare and the period pulse.
module tb_pwm_peripheral;

    localparam int unsigned P = 13;
    localparam int unsigned T = 256 * P;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] en_o = 16'h0000;
    logic [15:0] en_p = 16'h0000;
    logic [7:0]  duty = 8'h00;
    logic [15:0] out;
    logic        period_start;

    int unsigned n = 0;
    logic [7:0]  sh = 8'h00;
    int          checks = 0;
    int          errors = 0;
    int          hi0 = 0;
    int          hi1 = 0;
    int          first_ps = 0;

    pwm_peripheral #(.PRESCALE(P)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_o[7:0]),
        .en_reg_out_15_8 (en_o[15:8]),
        .en_reg_pwm_7_0  (en_p[7:0]),
        .en_reg_pwm_15_8 (en_p[15:8]),
        .pwm_duty_cycle  (duty),
        .out             (out),
        .period_start    (period_start)
    );

    always #5 clk = ~clk;

    // Pin levels after n edges since release: count is n/P modulo 256.
    function automatic logic [15:0] exp_out(int unsigned nn);
        int unsigned cnt;
        int unsigned d;
        logic        sig;
        logic [15:0] r;
        cnt = (nn / P) % 256;
`ifdef PWM_DUTY_SHADOW_EN
        d = int'(sh);
`else
        d = int'(duty);
`endif
        sig = (d == 255) || (cnt < d);
        for (int i = 0; i < 16; i++)
            r[i] = en_o[i] ? (en_p[i] ? sig : 1'b1) : 1'b0;
        return r;
    endfunction

    task automatic chk(input string tag, input int got, input int want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, want);
        end
    endtask

    task automatic step(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            n++;
            if (n % T == 0) sh = duty;
            #1;
            chk("out", int'(out), int'(exp_out(n)));
            chk("period_start", int'(period_start), int'(n % T == 0));
            hi0 += int'(out[0]);
            hi1 += int'(out[1]);
            if (period_start && first_ps == 0) first_ps = int'(n);
        end
    endtask

    task automatic to_boundary();
        do step(1); while (n % T != 0);
    endtask

    initial begin
        #1;
        chk("reset_out", int'(out), 0);
        chk("reset_ps", int'(period_start), 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        sh = 8'h00;

        en_o = 16'h00FF;
        en_p = 16'h0000;
        step(1);
        chk("static_on", int'(out), 16'h00FF);
        en_o = 16'h0000;
        step(1);
        chk("static_off", int'(out), 16'h0000);

        en_o = 16'h0001;
        en_p = 16'h0001;
        duty = 8'h80;
        to_boundary();
        chk("align_rise", int'(out[0]), 1);
        hi0 = 0;
        step(T);
        chk("duty80_hi", hi0, 1664);

        duty = 8'h00;
        to_boundary();
        hi0 = 0;
        step(2 * T);
        chk("duty00_hi", hi0, 0);
        duty = 8'hFF;
        to_boundary();
        hi0 = 0;
        step(2 * T);
        chk("dutyFF_hi", hi0, 2 * T);
        duty = 8'h01;
        to_boundary();
        hi0 = 0;
        step(T);
        chk("duty01_hi", hi0, 13);

        duty = 8'h40;
        to_boundary();
        hi0 = 0;
        step(32 * P);
        duty = 8'hC0;
        to_boundary();
`ifdef PWM_DUTY_SHADOW_EN
        chk("chg_cur_hi", hi0, 832);
`else
        chk("chg_cur_hi", hi0, 2496);
`endif
        hi0 = 0;
        step(T);
        chk("chg_next_hi", hi0, 2496);

        en_o = 16'hFFFF;
        en_p = 16'hAAAA;
        duty = 8'h40;
        to_boundary();
        hi1 = 0;
        step(T);
        chk("mixed_odd_hi", hi1, 832);
        chk("mixed_even", int'(out & 16'h5555), 16'h5555);
        step(P);
        chk("mixed_odd", int'(out & 16'hAAAA), 16'hAAAA);

        for (int s = 0; s < 30; s++) begin
            en_o = 16'($urandom);
            en_p = 16'($urandom);
            duty = 8'($urandom);
            step(int'($urandom_range(1, 400)));
        end

        en_o = 16'hFFFF;
        en_p = 16'h0000;
        to_boundary();
        step(int'(8'h90) * P);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_out", int'(out), 0);
        chk("rst_async_ps", int'(period_start), 0);
        @(posedge clk);
        #1;
        chk("rst_hold_out", int'(out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        sh = 8'h00;
        first_ps = 0;
        en_p = 16'hFFFF;
        duty = 8'h20;
        step(T + 2);
        chk("first_ps_edge", first_ps, int'(T));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
